// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Two-master round-robin arbiter with a fairness quantum, steering
//             the owning master onto the single-master BUS port.
//  Revision : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter int QUANTUM = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [15:0] m0_addr,
    input  logic [63:0] m0_dout,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [15:0] m1_addr,
    input  logic [63:0] m1_dout,
    output logic        m0_grant,
    output logic        m1_grant,
    output logic [63:0] m0_din,
    output logic [63:0] m1_din,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [15:0] bus_addr,
    output logic [63:0] bus_dout,
    input  logic [63:0] bus_din
);

    localparam logic [7:0] c_CNT_MAX = 8'(QUANTUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       w_other_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_state_nxt == ST_OWN0) begin
                r_last <= 1'b0;
            end else if (w_state_nxt == ST_OWN1) begin
                r_last <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_other_req = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Under contention the master that did not own last wins.
                if (m0_req && m1_req) begin
                    w_state_nxt = r_last ? ST_OWN0 : ST_OWN1;
                end else if (m0_req) begin
                    w_state_nxt = ST_OWN0;
                end else if (m1_req) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                w_other_req = m1_req;
                if (!m0_req) begin
                    w_state_nxt = m1_req ? ST_OWN1 : ST_IDLE;
                end else if (m1_req && (r_cnt == c_CNT_MAX)) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN1: begin
                w_other_req = m0_req;
                if (!m1_req) begin
                    w_state_nxt = m0_req ? ST_OWN0 : ST_IDLE;
                end else if (m0_req && (r_cnt == c_CNT_MAX)) begin
                    w_state_nxt = ST_OWN0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The quantum counter only runs while ownership is contested.
    always_comb begin
        w_cnt_nxt = 8'd0;
        if ((r_state != ST_IDLE) && (w_state_nxt == r_state) && w_other_req) begin
            w_cnt_nxt = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + 8'd1);
        end
    end

    always_comb begin
        m0_grant = (r_state == ST_OWN0);
        m1_grant = (r_state == ST_OWN1);
        bus_req  = 1'b0;
        bus_wr   = 1'b0;
        bus_addr = 16'd0;
        bus_dout = 64'd0;
        case (r_state)
            ST_OWN0: begin
                bus_req  = 1'b1;
                bus_wr   = m0_wr;
                bus_addr = m0_addr;
                bus_dout = m0_dout;
            end
            ST_OWN1: begin
                bus_req  = 1'b1;
                bus_wr   = m1_wr;
                bus_addr = m1_addr;
                bus_dout = m1_dout;
            end
            default: begin
                bus_req  = 1'b0;
            end
        endcase
    end

    assign m0_din = bus_din;
    assign m1_din = bus_din;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_arbiter
//  Purpose  : Directed self-checking bench for bus_arbiter (QUANTUM = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [15:0] m0_addr, m1_addr;
    logic [63:0] m0_dout, m1_dout;
    logic        m0_grant, m1_grant;
    logic [63:0] m0_din, m1_din;
    logic        bus_req, bus_wr;
    logic [15:0] bus_addr;
    logic [63:0] bus_dout;
    logic [63:0] bus_din;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.QUANTUM(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_wr    (m0_wr),
        .m0_addr  (m0_addr),
        .m0_dout  (m0_dout),
        .m1_req   (m1_req),
        .m1_wr    (m1_wr),
        .m1_addr  (m1_addr),
        .m1_dout  (m1_dout),
        .m0_grant (m0_grant),
        .m1_grant (m1_grant),
        .m0_din   (m0_din),
        .m1_din   (m1_din),
        .bus_req  (bus_req),
        .bus_wr   (bus_wr),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .bus_din  (bus_din)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status vector layout: {m0_grant, m1_grant, bus_req, bus_wr}
    task automatic test_reset();
        reset = 1'b1;
        m0_req = 1'b1;
        tick();
        tick();
        checks++;
        if ({m0_grant, m1_grant, bus_req, bus_wr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_status got %b expected 0000", {m0_grant, m1_grant, bus_req, bus_wr});
        end
        checks++;
        if ({bus_addr, bus_dout} !== 80'd0) begin
            errors++;
            $display("FAIL reset_bus got addr %h dout %h expected 0", bus_addr, bus_dout);
        end
        m0_req = 1'b0;
        reset = 1'b0;
        tick();
        checks++;
        if ({m0_grant, m1_grant, bus_req} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got %b expected 000", {m0_grant, m1_grant, bus_req});
        end
    endtask

    task automatic test_single();
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0600; m0_dout = 64'hffff;
        #1;
        checks++;
        if (m0_grant !== 1'b0) begin
            errors++;
            $display("FAIL single_pre_edge got grant %b expected 0", m0_grant);
        end
        tick();
        checks++;
        if ({m0_grant, m1_grant, bus_req, bus_wr} !== 4'b1011) begin
            errors++;
            $display("FAIL single_grant got %b expected 1011", {m0_grant, m1_grant, bus_req, bus_wr});
        end
        checks++;
        if (bus_addr !== 16'h0600 || bus_dout !== 64'hffff) begin
            errors++;
            $display("FAIL single_bus got addr %h dout %h expected 0600 ffff", bus_addr, bus_dout);
        end
        m0_addr = 16'h0608;
        #1;
        checks++;
        if (bus_addr !== 16'h0608) begin
            errors++;
            $display("FAIL single_addr_pass got %h expected 0608", bus_addr);
        end
        tick();
        checks++;
        if ({m0_grant, m1_grant} !== 2'b10) begin
            errors++;
            $display("FAIL single_hold got %b expected 10", {m0_grant, m1_grant});
        end
        m0_req = 1'b0;
        tick();
        checks++;
        if ({m0_grant, m1_grant, bus_req, bus_wr} !== 4'b0000 || bus_addr !== 16'd0) begin
            errors++;
            $display("FAIL single_release got %b addr %h expected 0000 addr 0000",
                     {m0_grant, m1_grant, bus_req, bus_wr}, bus_addr);
        end
        m0_wr = 1'b0;
    endtask

    task automatic test_simultaneous();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m0_addr = 16'h1234; m1_addr = 16'h7020;
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        checks++;
        if ({m0_grant, m1_grant} !== 2'b10 || bus_addr !== 16'h1234) begin
            errors++;
            $display("FAIL simul_first got %b addr %h expected 10 addr 1234", {m0_grant, m1_grant}, bus_addr);
        end
        m0_req = 1'b0;
        tick();
        checks++;
        if ({m0_grant, m1_grant, bus_req} !== 3'b011 || bus_addr !== 16'h7020) begin
            errors++;
            $display("FAIL simul_handover got %b addr %h expected 011 addr 7020",
                     {m0_grant, m1_grant, bus_req}, bus_addr);
        end
        m1_req = 1'b0;
        tick();
        checks++;
        if ({m0_grant, m1_grant, bus_req} !== 3'b000) begin
            errors++;
            $display("FAIL simul_idle got %b expected 000", {m0_grant, m1_grant, bus_req});
        end
    endtask

    task automatic test_round_robin();
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        checks++;
        if ({m0_grant, m1_grant} !== 2'b10) begin
            errors++;
            $display("FAIL rr_after_m1 got %b expected 10", {m0_grant, m1_grant});
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        checks++;
        if ({m0_grant, m1_grant} !== 2'b00) begin
            errors++;
            $display("FAIL rr_idle got %b expected 00", {m0_grant, m1_grant});
        end
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        checks++;
        if ({m0_grant, m1_grant} !== 2'b01) begin
            errors++;
            $display("FAIL rr_after_m0 got %b expected 01", {m0_grant, m1_grant});
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
    endtask

    task automatic test_quantum();
        logic [1:0] exp_g;
        m0_wr = 1'b0; m1_wr = 1'b1;
        m0_addr = 16'h0100; m1_addr = 16'h0200;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_g = (((i / 4) % 2) == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({m0_grant, m1_grant} !== exp_g) begin
                errors++;
                $display("FAIL quantum_cycle%0d got %b expected %b", i, {m0_grant, m1_grant}, exp_g);
            end
        end
        checks++;
        if (bus_wr !== 1'b1 || bus_addr !== 16'h0200) begin
            errors++;
            $display("FAIL quantum_owner_bus got wr %b addr %h expected 1 0200", bus_wr, bus_addr);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        checks++;
        if ({m0_grant, m1_grant, bus_req, bus_wr} !== 4'b0000 || bus_addr !== 16'd0 || bus_dout !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid got %b addr %h dout %h expected 0000 0 0",
                     {m0_grant, m1_grant, bus_req, bus_wr}, bus_addr, bus_dout);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({m0_grant, m1_grant} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_resume got %b expected 10", {m0_grant, m1_grant});
        end
    endtask

    task automatic test_readback();
        bus_din = 64'haaaa;
        #1;
        checks++;
        if (m0_din !== 64'haaaa || m1_din !== 64'haaaa) begin
            errors++;
            $display("FAIL readback_a got %h %h expected aaaa", m0_din, m1_din);
        end
        bus_din = 64'hbbbb;
        #1;
        checks++;
        if (m0_din !== 64'hbbbb || m1_din !== 64'hbbbb) begin
            errors++;
            $display("FAIL readback_b got %h %h expected bbbb", m0_din, m1_din);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
        bus_din = 64'h1234_5678_9abc_def0;
        #1;
        checks++;
        if (m0_din !== 64'h1234_5678_9abc_def0 || m1_din !== 64'h1234_5678_9abc_def0) begin
            errors++;
            $display("FAIL readback_idle got %h %h expected 123456789abcdef0", m0_din, m1_din);
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = 16'd0; m0_dout = 64'd0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = 16'd0; m1_dout = 64'd0;
        bus_din = 64'd0;
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_quantum();
        test_reset_mid();
        test_readback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
